alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_seq.sv | 170 +++++++++++++++++
 tb/tb_alu_seq.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants for the byte-serial ALU sequencer
// Purpose: flag bit indices, ALU opcode constants and the alu_seq state encoding.
// Ports: none (package).
package alu_pkg;

  // Bit positions inside the 4-bit flag vector {overflow, sign, carry, zero}
  localparam int ZERO  = 0;
  localparam int CARRY = 1;
  localparam int SIGN  = 2;
  localparam int OVF   = 3;

  // ALU opcodes
  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_AND = 4'h1;
  localparam logic [3:0] OP_OR  = 4'h2;
  localparam logic [3:0] OP_XOR = 4'h3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } alu_seq_state_t;

endpackage

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - byte-serial sequencer driving an external 8-bit combinational ALU
// Purpose: runs one NBYTES-wide ALU operation LSB byte first through an external
//   8-bit ALU, chaining carries, and assembles the word result and flags.
// Optional feature: define ALU_SEQ_ABORT_EN to add the abort input (RUN -> IDLE, no done).
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start                request, accepted only in IDLE
//   op, invert           ALU opcode / invert control, latched on accept
//   carry_in, chain      carry into byte 0; chain=1 ripples carry byte to byte
//   abort                (ALU_SEQ_ABORT_EN only) cancel the operation in RUN
//   a_in, b_in           operands
//   busy, done           in-flight indicator, one-cycle completion pulse
//   result, flags        assembled word result and {ovf, sign, carry, zero}
//   alu_a, alu_b         operand bytes to the ALU
//   alu_op, alu_invert, alu_carry_in, alu_oe   ALU controls (alu_oe=1 disables ALU output)
//   alu_res, alu_flags   ALU result byte and flags
module alu_seq
  import alu_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [3:0]            op,
  input  logic                  invert,
  input  logic                  carry_in,
  input  logic                  chain,
`ifdef ALU_SEQ_ABORT_EN
  input  logic                  abort,
`endif
  input  logic [8*NBYTES-1:0]   a_in,
  input  logic [8*NBYTES-1:0]   b_in,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   result,
  output logic [3:0]            flags,
  output logic [7:0]            alu_a,
  output logic [7:0]            alu_b,
  output logic [3:0]            alu_op,
  output logic                  alu_invert,
  output logic                  alu_carry_in,
  output logic                  alu_oe,
  input  logic [7:0]            alu_res,
  input  logic [3:0]            alu_flags
);

  localparam int IDXW = $clog2(NBYTES);
  localparam logic [IDXW-1:0] LAST = IDXW'(NBYTES - 1);

  alu_seq_state_t            state_q;
  logic [IDXW-1:0]           idx_q;
  logic [3:0]                op_q;
  logic                      inv_q;
  logic                      cin_q;
  logic                      chain_q;
  logic [NBYTES-1:0][7:0]    a_q;
  logic [NBYTES-1:0][7:0]    b_q;
  logic [NBYTES-1:0][7:0]    acc_q;
  logic                      carry_q;
  logic                      busy_q;
  logic                      done_q;
  logic [NBYTES-1:0][7:0]    result_q;
  logic [3:0]                flags_q;

  logic [NBYTES-1:0][7:0]    res_d;
  logic [3:0]                flags_d;
  logic                      in_run;
  logic                      abort_req;

`ifdef ALU_SEQ_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign in_run = (state_q == RUN);

  // ALU operands are parked at zero whenever the ALU output is disabled
  assign alu_a        = in_run ? a_q[idx_q] : 8'h00;
  assign alu_b        = in_run ? b_q[idx_q] : 8'h00;
  assign alu_carry_in = in_run ? (((idx_q == '0) || !chain_q) ? cin_q : carry_q) : 1'b0;
  assign alu_oe       = !in_run;
  assign alu_op       = op_q;
  assign alu_invert   = inv_q;

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign flags  = flags_q;

  // Word as it stands once the current byte is merged in; on the last byte
  // this is the final result and its zero flag covers every byte.
  always_comb begin
    res_d             = acc_q;
    res_d[idx_q]      = alu_res;
    flags_d           = '0;
    flags_d[ZERO]     = (res_d == '0);
    flags_d[CARRY]    = alu_flags[CARRY];
    flags_d[SIGN]     = alu_flags[SIGN];
    flags_d[OVF]      = alu_flags[OVF];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      op_q     <= '0;
      inv_q    <= 1'b0;
      cin_q    <= 1'b0;
      chain_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            op_q    <= op;
            inv_q   <= invert;
            cin_q   <= carry_in;
            chain_q <= chain;
            a_q     <= a_in;
            b_q     <= b_in;
            acc_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (abort_req) begin
            idx_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            carry_q <= alu_flags[CARRY];
            acc_q   <= res_d;
            if (idx_q == LAST) begin
              idx_q    <= '0;
              done_q   <= 1'b1;
              result_q <= res_d;
              flags_q  <= flags_d;
              state_q  <= DONE;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq with a behavioural 8-bit ALU
module tb_alu_seq;
  import alu_pkg::*;

  localparam int NBYTES = 4;
  localparam int W = 8 * NBYTES;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [3:0]    op;
  logic          invert;
  logic          carry_in;
  logic          chain;
  logic          abort;
  logic [W-1:0]  a_in;
  logic [W-1:0]  b_in;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic [3:0]    flags;
  logic [7:0]    alu_a;
  logic [7:0]    alu_b;
  logic [3:0]    alu_op;
  logic          alu_invert;
  logic          alu_carry_in;
  logic          alu_oe;
  logic [7:0]    alu_res;
  logic [3:0]    alu_flags;

  always #5 clk = ~clk;

  alu_seq #(.NBYTES(NBYTES)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .op           (op),
    .invert       (invert),
    .carry_in     (carry_in),
    .chain        (chain),
`ifdef ALU_SEQ_ABORT_EN
    .abort        (abort),
`endif
    .a_in         (a_in),
    .b_in         (b_in),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .flags        (flags),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_invert   (alu_invert),
    .alu_carry_in (alu_carry_in),
    .alu_oe       (alu_oe),
    .alu_res      (alu_res),
    .alu_flags    (alu_flags)
  );

  // Behavioural ALU: invert complements operand b; flags are {ovf, sign, carry, zero}
  logic [7:0] m_bb;
  logic [8:0] m_sum;
  logic [7:0] m_r;
  logic       m_c;
  logic       m_v;
  always_comb begin
    m_bb  = alu_invert ? ~alu_b : alu_b;
    m_sum = {1'b0, alu_a} + {1'b0, m_bb} + {8'h00, alu_carry_in};
    m_r   = alu_a;
    m_c   = 1'b0;
    m_v   = 1'b0;
    case (alu_op)
      OP_ADD: begin
        m_r = m_sum[7:0];
        m_c = m_sum[8];
        m_v = (alu_a[7] == m_bb[7]) && (m_sum[7] != alu_a[7]);
      end
      OP_AND:  m_r = alu_a & m_bb;
      OP_OR:   m_r = alu_a | m_bb;
      OP_XOR:  m_r = alu_a ^ m_bb;
      default: m_r = alu_a;
    endcase
    if (alu_oe) begin
      alu_res   = 8'h00;
      alu_flags = 4'h0;
    end else begin
      alu_res   = m_r;
      alu_flags = {m_v, m_r[7], m_c, (m_r == 8'h00)};
    end
  end

  typedef struct {
    logic [3:0]   op;
    logic         inv;
    logic         cin;
    logic         chain;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [3:0]   flg;
  } vec_t;

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   flg;
  } exp_t;

  vec_t vecs[10];
  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;
  logic prev_done = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every done pops the oldest expected result
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      check("done_single_cycle", {63'd0, prev_done}, 64'd0);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 expected no done");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_result", {32'd0, result}, {32'd0, e.res});
        check("sb_flags", {60'd0, flags}, {60'd0, e.flg});
      end
    end
    prev_done = done;
  end

  task automatic drive(input vec_t v);
    op       = v.op;
    invert   = v.inv;
    carry_in = v.cin;
    chain    = v.chain;
    a_in     = v.a;
    b_in     = v.b;
  endtask

  task automatic wait_done(input string name, input int exp_lat);
    int cyc = 0;
    bit got = 0;
    while (cyc < 20 && !got) begin
      @(negedge clk);
      cyc++;
      if (done) got = 1;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no done in 20 cycles expected done", name);
    end else begin
      check(name, cyc, exp_lat);
    end
  endtask

  // Issue one op from IDLE (called at a negedge), scoreboard its result, check latency
  task automatic run_vec(input vec_t v);
    exp_t e;
    drive(v);
    start = 1'b1;
    e.res = v.res;
    e.flg = v.flg;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    a_in  = $urandom();
    b_in  = $urandom();
    wait_done("latency", NBYTES + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    vec_t  v;
    int    dc[$];
    int    cnt0;
    logic [W-1:0] r_keep;

    //           op      inv   cin   chain a             b             res           flags {v,s,c,z}
    vecs[0] = '{OP_ADD, 1'b0, 1'b0, 1'b1, 32'h0000FFFF, 32'h00000001, 32'h00010000, 4'b0000};
    vecs[1] = '{OP_ADD, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0011};
    vecs[2] = '{OP_ADD, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFF00, 4'b0100};
    vecs[3] = '{OP_ADD, 1'b0, 1'b0, 1'b1, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1100};
    vecs[4] = '{OP_ADD, 1'b0, 1'b1, 1'b1, 32'h00000000, 32'h00000000, 32'h00000001, 4'b0000};
    vecs[5] = '{OP_ADD, 1'b1, 1'b1, 1'b1, 32'h00000005, 32'h00000005, 32'h00000000, 4'b0011};
    vecs[6] = '{OP_AND, 1'b0, 1'b0, 1'b1, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b0100};
    vecs[7] = '{OP_XOR, 1'b0, 1'b0, 1'b1, 32'h12345678, 32'h12345678, 32'h00000000, 4'b0001};
    vecs[8] = '{OP_OR,  1'b0, 1'b0, 1'b1, 32'h00000000, 32'h80000000, 32'h80000000, 4'b0100};
    vecs[9] = '{OP_ADD, 1'b1, 1'b1, 1'b1, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 4'b0100};

    rst = 1'b1; start = 1'b0; abort = 1'b0;
    drive(vecs[0]);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_busy",   {63'd0, busy}, 64'd0);
    check("rst_done",   {63'd0, done}, 64'd0);
    check("rst_result", {32'd0, result}, 64'd0);
    check("rst_flags",  {60'd0, flags}, 64'd0);
    check("rst_alu_oe", {63'd0, alu_oe}, 64'd1);
    check("idle_alu_ab", {48'd0, alu_a, alu_b}, 64'd0);
    check("idle_alu_cin", {63'd0, alu_carry_in}, 64'd0);

    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i]);
      @(negedge clk);
    end

    // Result holds across idle cycles until the next done
    repeat (3) @(negedge clk);
    check("result_hold", {32'd0, result}, {32'd0, vecs[9].res});

    // start held high: accepts at cycles 0,6,12,18 -> dones at 5,11,17,23
    v = '{OP_ADD, 1'b0, 1'b0, 1'b1, 32'h00000001, 32'h00000001, 32'h00000002, 4'b0000};
    drive(v);
    for (int i = 0; i < 4; i++) sb.push_back('{v.res, v.flg});
    start = 1'b1;
    for (int c = 1; c <= 28; c++) begin
      @(negedge clk);
      if (done) dc.push_back(c);
      if (c == 20) start = 1'b0;
    end
    check("stream_done_count", dc.size(), 4);
    for (int i = 0; i < 4 && i < dc.size(); i++)
      check("stream_done_cycle", dc[i], 5 + 6 * i);

    // Reset at RUN byte 2: no done, everything cleared
    drive(vecs[3]);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_busy", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrun_rst_busy",   {63'd0, busy}, 64'd0);
    check("midrun_rst_alu_oe", {63'd0, alu_oe}, 64'd1);
    check("midrun_rst_result", {32'd0, result}, 64'd0);
    check("midrun_rst_flags",  {60'd0, flags}, 64'd0);
    check("midrun_rst_done",   {63'd0, done}, 64'd0);
    cnt0 = done_cnt;
    repeat (8) @(negedge clk);
    check("midrun_rst_no_done", done_cnt - cnt0, 0);

    // start sampled together with rst is ignored
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("start_with_rst", {63'd0, busy}, 64'd0);

`ifdef ALU_SEQ_ABORT_EN
    run_vec(vecs[0]);
    @(negedge clk);
    r_keep = vecs[0].res;
    drive(vecs[3]);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_busy",   {63'd0, busy}, 64'd0);
    check("abort_result", {32'd0, result}, {32'd0, r_keep});
    check("abort_flags",  {60'd0, flags}, {60'd0, vecs[0].flg});
    cnt0 = done_cnt;
    repeat (8) @(negedge clk);
    check("abort_no_done", done_cnt - cnt0, 0);
`else
    r_keep = '0;
`endif

    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
